// File: rtl/neuron_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// neuron_ctrl_pkg
// Shared types and elaboration-time helpers for the neuron slice control
// sequencer.
//   neuron_ctrl_state_t : sequencer state encoding (3 bits)
//   ptr_width()         : address width needed to index DEPTH entries
//   cnt_width()         : width needed to hold a count of 0..max_val
// -----------------------------------------------------------------------------
package neuron_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD_DATA   = 3'd1,
    ST_LOAD_THRESH = 3'd2,
    ST_COMPUTE     = 3'd3,
    ST_DRAIN       = 3'd4,
    ST_DONE        = 3'd5
  } neuron_ctrl_state_t;

  // Pointer width for a vector of 'depth' entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Width of a counter that must hold values 0..max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/neuron_ctrl_seq_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Loadable down-counter shared by the threshold-beat and pipeline-drain
// phases of the sequencer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : synchronous clear to zero (abort / restart)
//   load_i       : load load_val_i (has priority over dec_i)
//   load_val_i   : number of units in the phase being started
//   dec_i        : consume one unit; holds at zero
//   done_o       : one unit left, so a decrement this cycle ends the phase
// -----------------------------------------------------------------------------
module phase_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_o = (count_q == W'(1));

endmodule

// File: rtl/neuron_ctrl_seq.sv
// -----------------------------------------------------------------------------
// neuron_ctrl_seq
// Control sequencer for one neuron compute slice: loads the input vector and
// threshold word, runs the multiply/accumulate sweep, drains the MAC pipeline
// and hands the result to the readout logic.
//
// Parameters: DEPTH (vector length), THRESH_BEATS (threshold beats),
//             PIPE_LAT (drain cycles), AUTO_RESTART (out_ack re-arms),
//             AW (derived pointer width).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   chip_sel          : slice select; low aborts to IDLE on the next edge
//   wr_en / wr_ready  : write beat handshake
//   rst_mem           : one-cycle clear pulse to memories/MAC
//   mul_mem_en        : multiplier memory enable (COMPUTE)
//   ac_mem_en         : accumulator memory enable (COMPUTE)
//   wr_data_ptr       : write address
//   rd_data_ptr       : read address
//   threshold_ready   : cycle after each accepted threshold beat
//   output_ready      : result valid (DONE)
//   out_ack           : readout consumed the result
//   busy              : sequencer not idle
//   op_cycles [31:0]  : only with NEURON_CTRL_PERF_EN defined; cycles from
//                       the first accepted data beat to DONE entry, saturating
// -----------------------------------------------------------------------------
module neuron_ctrl_seq
  import neuron_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH        = 64,
  parameter  int unsigned THRESH_BEATS = 2,
  parameter  int unsigned PIPE_LAT     = 3,
  parameter  int unsigned AUTO_RESTART = 0,
  localparam int unsigned AW           = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          chip_sel,
  input  logic          wr_en,
  output logic          wr_ready,
  output logic          rst_mem,
  output logic          mul_mem_en,
  output logic          ac_mem_en,
  output logic [AW-1:0] wr_data_ptr,
  output logic [AW-1:0] rd_data_ptr,
  output logic          threshold_ready,
  output logic          output_ready,
  input  logic          out_ack,
  output logic          busy
`ifdef NEURON_CTRL_PERF_EN
  ,
  output logic [31:0]   op_cycles
`endif
);

  localparam int unsigned CNT_MAX = (THRESH_BEATS > PIPE_LAT) ? THRESH_BEATS : PIPE_LAT;
  localparam int unsigned CW      = cnt_width(CNT_MAX);

  localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] THRESH_LOAD = CW'(THRESH_BEATS);
  localparam logic [CW-1:0] DRAIN_LOAD  = CW'(PIPE_LAT);

  neuron_ctrl_state_t state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               rst_mem_q, rst_mem_d;
  logic               thr_rdy_q, thr_rdy_d;
  logic               cs_q;

  logic               cnt_clr, cnt_load, cnt_dec, cnt_done;
  logic [CW-1:0]      cnt_val;
  logic               beat_acc;

  // cs_q keeps beats out during the cycle chip_sel first rises (and during
  // reset), so no beat lands before the rst_mem clear pulse has been issued.
  assign wr_ready = chip_sel && cs_q && !rst_mem_q &&
                    (state_q inside {ST_IDLE, ST_LOAD_DATA, ST_LOAD_THRESH});
  assign beat_acc = wr_en && wr_ready;

  phase_counter #(
    .W (CW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rst_mem_d = 1'b0;
    thr_rdy_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;

    if (!chip_sel) begin
      // Abort: partial vector/compute is discarded, no clear pulse.
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_clr  = 1'b1;
    end else begin
      rst_mem_d = !cs_q;
      unique case (state_q)
        ST_IDLE: begin
          if (beat_acc) begin
            wr_ptr_d = AW'(1);
            state_d  = ST_LOAD_DATA;
          end
        end
        ST_LOAD_DATA: begin
          if (beat_acc) begin
            if (wr_ptr_q == PTR_LAST) begin
              state_d  = ST_LOAD_THRESH;
              cnt_load = 1'b1;
              cnt_val  = THRESH_LOAD;
            end else begin
              wr_ptr_d = wr_ptr_q + AW'(1);
            end
          end
        end
        ST_LOAD_THRESH: begin
          if (beat_acc) begin
            thr_rdy_d = 1'b1;
            cnt_dec   = 1'b1;
            if (cnt_done) begin
              state_d  = ST_COMPUTE;
              rd_ptr_d = '0;
            end
          end
        end
        ST_COMPUTE: begin
          if (rd_ptr_q == PTR_LAST) begin
            state_d  = ST_DRAIN;
            cnt_load = 1'b1;
            cnt_val  = DRAIN_LOAD;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
        ST_DRAIN: begin
          cnt_dec = 1'b1;
          if (cnt_done) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if ((AUTO_RESTART != 0) && out_ack) begin
            state_d   = ST_IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            rst_mem_d = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rst_mem_q <= 1'b0;
      thr_rdy_q <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rst_mem_q <= rst_mem_d;
      thr_rdy_q <= thr_rdy_d;
      cs_q      <= chip_sel;
    end
  end

  assign rst_mem         = rst_mem_q;
  assign mul_mem_en      = (state_q == ST_COMPUTE);
  assign ac_mem_en       = (state_q == ST_COMPUTE);
  assign wr_data_ptr     = wr_ptr_q;
  assign rd_data_ptr     = rd_ptr_q;
  assign threshold_ready = thr_rdy_q;
  assign output_ready    = (state_q == ST_DONE);
  assign busy            = (state_q != ST_IDLE);

`ifdef NEURON_CTRL_PERF_EN
  logic [31:0] op_cycles_q, op_cycles_d;

  // Any return to IDLE (abort, restart) clears; the first accepted beat is
  // cycle zero, and the count stops once DONE is entered.
  always_comb begin
    op_cycles_d = op_cycles_q;
    if (state_d == ST_IDLE) begin
      op_cycles_d = '0;
    end else if ((state_q inside {ST_LOAD_DATA, ST_LOAD_THRESH, ST_COMPUTE, ST_DRAIN}) &&
                 (op_cycles_q != '1)) begin
      op_cycles_d = op_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cycles_q <= '0;
    end else begin
      op_cycles_q <= op_cycles_d;
    end
  end

  assign op_cycles = op_cycles_q;
`endif

endmodule

// File: tb/tb_neuron_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_neuron_ctrl_seq
// Two sequencer instances: u_a (DEPTH=64, THRESH_BEATS=2, PIPE_LAT=3,
// no auto-restart) and u_c (DEPTH=5, THRESH_BEATS=1, PIPE_LAT=1,
// auto-restart). Expected behaviour comes from a phase/timeline model:
// accepted-beat count n and cycles since compute start c determine every
// output. Honours NEURON_CTRL_PERF_EN.
// -----------------------------------------------------------------------------
module tb_neuron_ctrl_seq;

  localparam int A_DEPTH = 64;
  localparam int A_TB    = 2;
  localparam int A_PL    = 3;
  localparam int C_DEPTH = 5;
  localparam int C_TB    = 1;
  localparam int C_PL    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cs_a, we_a, ack_a, wr_ready_a, rst_mem_a, mul_a, ac_a, thr_a, out_a, busy_a;
  logic [5:0] wp_a, rp_a;
  logic       cs_c, we_c, ack_c, wr_ready_c, rst_mem_c, mul_c, ac_c, thr_c, out_c, busy_c;
  logic [2:0] wp_c, rp_c;
`ifdef NEURON_CTRL_PERF_EN
  logic [31:0] opc_a, opc_c;
`endif

  neuron_ctrl_seq #(
    .DEPTH(A_DEPTH), .THRESH_BEATS(A_TB), .PIPE_LAT(A_PL), .AUTO_RESTART(0)
  ) u_a (
    .clk(clk), .rst(rst), .chip_sel(cs_a), .wr_en(we_a), .wr_ready(wr_ready_a),
    .rst_mem(rst_mem_a), .mul_mem_en(mul_a), .ac_mem_en(ac_a),
    .wr_data_ptr(wp_a), .rd_data_ptr(rp_a), .threshold_ready(thr_a),
    .output_ready(out_a), .out_ack(ack_a), .busy(busy_a)
`ifdef NEURON_CTRL_PERF_EN
    , .op_cycles(opc_a)
`endif
  );

  neuron_ctrl_seq #(
    .DEPTH(C_DEPTH), .THRESH_BEATS(C_TB), .PIPE_LAT(C_PL), .AUTO_RESTART(1)
  ) u_c (
    .clk(clk), .rst(rst), .chip_sel(cs_c), .wr_en(we_c), .wr_ready(wr_ready_c),
    .rst_mem(rst_mem_c), .mul_mem_en(mul_c), .ac_mem_en(ac_c),
    .wr_data_ptr(wp_c), .rd_data_ptr(rp_c), .threshold_ready(thr_c),
    .output_ready(out_c), .out_ack(ack_c), .busy(busy_c)
`ifdef NEURON_CTRL_PERF_EN
    , .op_cycles(opc_c)
`endif
  );

  typedef struct packed {
    int         wr_ptr;
    int         rd_ptr;
    int         opc;
    logic [5:0] flags;     // {busy, mul_en, ac_en, threshold_ready, output_ready, rst_mem}
    logic       wr_ready;
  } obs_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int p_depth(input int idx); return (idx == 0) ? A_DEPTH : C_DEPTH; endfunction
  function automatic int p_tb(input int idx);    return (idx == 0) ? A_TB    : C_TB;    endfunction
  function automatic int p_pl(input int idx);    return (idx == 0) ? A_PL    : C_PL;    endfunction

  function automatic obs_t sample(input int idx);
    obs_t o;
    o.opc = 0;
    if (idx == 0) begin
      o.flags    = {busy_a, mul_a, ac_a, thr_a, out_a, rst_mem_a};
      o.wr_ptr   = int'(wp_a);
      o.rd_ptr   = int'(rp_a);
      o.wr_ready = wr_ready_a;
`ifdef NEURON_CTRL_PERF_EN
      o.opc      = int'(opc_a);
`endif
    end else begin
      o.flags    = {busy_c, mul_c, ac_c, thr_c, out_c, rst_mem_c};
      o.wr_ptr   = int'(wp_c);
      o.rd_ptr   = int'(rp_c);
      o.wr_ready = wr_ready_c;
`ifdef NEURON_CTRL_PERF_EN
      o.opc      = int'(opc_c);
`endif
    end
    return o;
  endfunction

  task automatic drive(input int idx, input logic cs, input logic we, input logic ack);
    if (idx == 0) begin
      cs_a = cs; we_a = we; ack_a = ack;
    end else begin
      cs_c = cs; we_c = we; ack_c = ack;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Toggle chip_sel low->high: expect one rst_mem cycle in which a write
  // request is refused, then an idle, empty slice.
  task automatic arm(input int idx);
    obs_t o;
    drive(idx, 1'b0, 1'b0, 1'b0);
    tick();
    drive(idx, 1'b1, 1'b0, 1'b0);
    tick();
    o = sample(idx);
    check("arm_rst_mem_flags", 32'(o.flags), 32'(6'b000001));
    drive(idx, 1'b1, 1'b1, 1'b0);
    #1;
    o = sample(idx);
    check("arm_wr_ready_during_clear", 32'(o.wr_ready), 32'(1'b0));
    tick();
    o = sample(idx);
    check("arm_no_beat_flags", 32'(o.flags), 32'(6'b000000));
    check("arm_no_beat_wr_ptr", o.wr_ptr, 0);
    drive(idx, 1'b1, 1'b0, 1'b0);
  endtask

  // One operation on instance idx. stall_pct: random wr_en drop rate;
  // stall_at/stall_len: forced gap once n beats are in; abort_rd: drop
  // chip_sel when rd_data_ptr reaches it; rst_mid: assert rst after the
  // first threshold beat. span = edges from first accepted beat to DONE.
  task automatic run_op(input int idx, input int stall_pct, input int stall_at,
                        input int stall_len, input int abort_rd, input bit rst_mid,
                        output int span);
    int d, tb, pl, n, c, first, stalls, stall_left, steps;
    bit fin, stall_used, we, acc;
    logic [5:0] ef;
    obs_t o;
    d = p_depth(idx); tb = p_tb(idx); pl = p_pl(idx);
    n = 0; c = -1; first = -1; stalls = 0; stall_left = 0; steps = 0;
    fin = 1'b0; stall_used = 1'b0; span = -1;
    while (!fin && steps < 1000) begin
      steps++;
      if (rst_mid && n == d + 1) begin
        rst = 1'b1;
        drive(idx, 1'b1, 1'b1, 1'b0);
        tick();
        o = sample(idx);
        check("rst_mid_flags", 32'(o.flags), 32'(6'b000000));
        check("rst_mid_wr_ptr", o.wr_ptr, 0);
        check("rst_mid_rd_ptr", o.rd_ptr, 0);
        check("rst_mid_wr_ready", 32'(o.wr_ready), 32'(1'b0));
        rst = 1'b0;
        drive(idx, 1'b0, 1'b0, 1'b0);
        fin = 1'b1;
      end else if (abort_rd >= 0 && c == abort_rd) begin
        drive(idx, 1'b0, 1'b0, 1'b0);
        tick();
        o = sample(idx);
        check("abort_flags", 32'(o.flags), 32'(6'b000000));
        check("abort_wr_ptr", o.wr_ptr, 0);
        check("abort_rd_ptr", o.rd_ptr, 0);
`ifdef NEURON_CTRL_PERF_EN
        check("abort_op_cycles", o.opc, 0);
`endif
        fin = 1'b1;
      end else if (c == d + pl) begin
        span = cyc - first;
        check("done_span", span, (d + tb - 1) + stalls + d + pl);
`ifdef NEURON_CTRL_PERF_EN
        o = sample(idx);
        check("op_cycles_at_done", o.opc, span);
`endif
        fin = 1'b1;
      end else begin
        we = 1'b0;
        if (n < d + tb) begin
          if (!stall_used && n == stall_at) begin
            stall_left = stall_len;
            stall_used = 1'b1;
          end
          if (stall_left > 0) stall_left--;
          else we = ($urandom_range(99) >= stall_pct);
        end
        drive(idx, 1'b1, we, 1'b0);
        #1;
        o = sample(idx);
        check("wr_ready", 32'(o.wr_ready), 32'(n < d + tb));
        acc = we && (n < d + tb);
        if (first >= 0 && !acc && n < d + tb) stalls++;
        tick();
        if (acc) begin
          n++;
          if (first < 0) first = cyc;
        end
        if (c >= 0) c++;
        else if (acc && n == d + tb) c = 0;
        o = sample(idx);
        ef = {n > 0, (c >= 0 && c < d), (c >= 0 && c < d), (acc && n > d), (c >= d + pl), 1'b0};
        check("flags", 32'(o.flags), 32'(ef));
        check("wr_ptr", o.wr_ptr, (n >= d) ? d - 1 : n);
        check("rd_ptr", o.rd_ptr, (c < 0) ? 0 : ((c < d) ? c : d - 1));
      end
    end
    check("run_finished", 32'(fin), 32'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int span_a1, span_tmp, span_c1, span_c2;
    obs_t o;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    o = sample(0);
    check("reset_flags_a", 32'(o.flags), 32'(6'b000000));
    check("reset_ptrs_a", o.wr_ptr + o.rd_ptr, 0);
    o = sample(1);
    check("reset_flags_c", 32'(o.flags), 32'(6'b000000));
    rst = 1'b0;

    // Contiguous run: first beat E0, DONE after E132.
    arm(0);
    run_op(0, 0, -1, 0, -1, 1'b0, span_a1);
    check("contig_span_132", span_a1, 132);

    // No auto-restart: out_ack is ignored, result held until chip_sel low.
    drive(0, 1'b1, 1'b0, 1'b1);
    tick();
    o = sample(0);
    check("ack_ignored_flags", 32'(o.flags), 32'(6'b100010));
    drive(0, 1'b1, 1'b0, 1'b0);
    tick();
    o = sample(0);
    check("ack_ignored_hold", 32'(o.flags), 32'(6'b100010));
`ifdef NEURON_CTRL_PERF_EN
    check("op_cycles_frozen", o.opc, span_a1);
`endif
    drive(0, 1'b0, 1'b0, 1'b0);
    tick();
    o = sample(0);
    check("cs_low_from_done_flags", 32'(o.flags), 32'(6'b000000));
    check("cs_low_from_done_ptrs", o.wr_ptr + o.rd_ptr, 0);

    // Back-pressure: 5-cycle gap at wr_ptr=20 delays completion by 5.
    arm(0);
    run_op(0, 0, 20, 5, -1, 1'b0, span_tmp);
    check("stall_delay_5", span_tmp - span_a1, 5);

    // Random back-pressure.
    arm(0);
    run_op(0, 30, -1, 0, -1, 1'b0, span_tmp);

    // Abort at rd_ptr=30, then re-arm and a full run.
    arm(0);
    run_op(0, 0, -1, 0, 30, 1'b0, span_tmp);
    arm(0);
    run_op(0, 20, -1, 0, -1, 1'b0, span_tmp);

    // Reset during LOAD_THRESH.
    arm(0);
    run_op(0, 10, -1, 0, -1, 1'b1, span_tmp);

    // Small instance with auto-restart.
    arm(1);
    run_op(1, 0, -1, 0, -1, 1'b0, span_c1);
    check("small_contig_span", span_c1, 11);
    drive(1, 1'b1, 1'b0, 1'b1);
    tick();
    o = sample(1);
    check("restart_flags", 32'(o.flags), 32'(6'b000001));
    check("restart_ptrs", o.wr_ptr + o.rd_ptr, 0);
`ifdef NEURON_CTRL_PERF_EN
    check("restart_op_cycles", o.opc, 0);
`endif
    drive(1, 1'b1, 1'b1, 1'b0);
    #1;
    o = sample(1);
    check("restart_wr_ready", 32'(o.wr_ready), 32'(1'b0));
    drive(1, 1'b1, 1'b0, 1'b0);
    tick();
    o = sample(1);
    check("restart_settled", 32'(o.flags), 32'(6'b000000));
    run_op(1, 0, -1, 0, -1, 1'b0, span_c2);
    check("restart_same_span", span_c2, span_c1);

    // out_ack together with chip_sel low: abort wins, no clear pulse.
    drive(1, 1'b0, 1'b0, 1'b1);
    tick();
    o = sample(1);
    check("ack_vs_abort_flags", 32'(o.flags), 32'(6'b000000));
    check("ack_vs_abort_ptrs", o.wr_ptr + o.rd_ptr, 0);

    for (int k = 0; k < 3; k++) begin
      arm(1);
      run_op(1, 40, -1, 0, -1, 1'b0, span_tmp);
    end
    arm(1);
    run_op(1, 0, -1, 0, 3, 1'b0, span_tmp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
